oam_dma_arb: RTL

OAM_DMA_ARB -- requirements
Module: oam_dma_arb

---
 rtl/typepkg.sv | 21 ++
 rtl/sys_if.sv | 6 +
 rtl/oam_dma_arb.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/typepkg.sv
// Shared state encoding, default bus addresses and decode helper for the OAM DMA arbiter.
package typepkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_REG_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_PORT_DEFAULT = 16'h2004;
  localparam logic [7:0]  LAST_CNT         = 8'hFF;

  function automatic logic is_trigger(input logic we, input logic [15:0] addr,
                                      input logic [15:0] reg_addr);
    return we && (addr == reg_addr);
  endfunction

endpackage

// File: rtl/sys_if.sv
// Clock and asynchronous active-low reset bundle shared by system blocks.
interface sys_if;
  logic clk;
  logic n_reset;
  modport sink (input clk, input n_reset);
endinterface

// File: rtl/oam_dma_arb.sv
// OAM DMA arbiter: halts the CPU and copies one 256-byte page to the OAM port.
// Optional macro OAM_DMA_ALIGN_EN adds the read/write parity alignment cycle.
module oam_dma_arb
  import typepkg::*;
#(
  parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
  parameter logic [15:0] OAM_PORT = OAM_PORT_DEFAULT
) (
  sys_if.sink         sys,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        dma_busy
);

  dma_state_t  state_r;
  dma_state_t  state_s;
  logic [7:0]  page_r;
  logic [7:0]  cnt_r;
  logic [7:0]  byte_r;
  logic        cpu_rdy_r;
  logic        dma_busy_r;
  logic        trigger_s;
  logic        last_s;
  logic        bus_we_s;
  logic [15:0] bus_addr_s;
  logic [7:0]  bus_dout_s;
`ifdef OAM_DMA_ALIGN_EN
  logic        parity_r;
`endif

  assign trigger_s = (state_r == IDLE) && is_trigger(cpu_we, cpu_addr, DMA_REG);
  assign last_s    = (state_r == WRITE) && (cnt_r == LAST_CNT);

  // State register; busy is taken from the next state so it lines up with state_r.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      state_r    <= IDLE;
      dma_busy_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      dma_busy_r <= (state_s != IDLE);
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (trigger_s) state_s = HALT;
        else           state_s = IDLE;
      end
      HALT: begin
        if (cpu_we) begin
          state_s = HALT;
        end else begin
`ifdef OAM_DMA_ALIGN_EN
          if (parity_r) state_s = ALIGN;
          else          state_s = READ;
`else
          state_s = READ;
`endif
        end
      end
      ALIGN: state_s = READ;
      READ:  state_s = WRITE;
      WRITE: begin
        if (cnt_r == LAST_CNT) state_s = IDLE;
        else                   state_s = READ;
      end
      default: state_s = IDLE;
    endcase
  end

  // Source page, transfer counter and the byte carried from READ to WRITE.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      page_r <= 8'h00;
      cnt_r  <= 8'h00;
      byte_r <= 8'h00;
    end else begin
      if (trigger_s) begin
        page_r <= cpu_dout;
        cnt_r  <= 8'h00;
      end else if (state_r == WRITE) begin
        page_r <= page_r;
        cnt_r  <= cnt_r + 8'h01;
      end else begin
        page_r <= page_r;
        cnt_r  <= cnt_r;
      end
      if (state_r == READ) byte_r <= bus_din;
      else                 byte_r <= byte_r;
    end
  end

  // CPU ready drops after the trigger edge and returns after the last write.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) begin
      cpu_rdy_r <= 1'b1;
    end else if (trigger_s) begin
      cpu_rdy_r <= 1'b0;
    end else if (last_s || (state_r == IDLE)) begin
      cpu_rdy_r <= 1'b1;
    end else begin
      cpu_rdy_r <= cpu_rdy_r;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  // Free-running read/write phase; ALIGN is inserted when HALT ends on the odd phase.
  always_ff @(posedge sys.clk or negedge sys.n_reset) begin
    if (!sys.n_reset) parity_r <= 1'b0;
    else              parity_r <= ~parity_r;
  end
`endif

  // Bus mux: CPU owns the bus outside READ/WRITE, ALIGN suppresses its strobe.
  always_comb begin
    bus_we_s   = cpu_we;
    bus_addr_s = cpu_addr;
    bus_dout_s = cpu_dout;
    case (state_r)
      IDLE, HALT: begin
        bus_we_s   = cpu_we;
        bus_addr_s = cpu_addr;
        bus_dout_s = cpu_dout;
      end
      ALIGN: begin
        bus_we_s   = 1'b0;
        bus_addr_s = cpu_addr;
        bus_dout_s = cpu_dout;
      end
      READ: begin
        bus_we_s   = 1'b0;
        bus_addr_s = {page_r, cnt_r};
        bus_dout_s = byte_r;
      end
      WRITE: begin
        bus_we_s   = 1'b1;
        bus_addr_s = OAM_PORT;
        bus_dout_s = byte_r;
      end
      default: begin
        bus_we_s   = 1'b0;
        bus_addr_s = cpu_addr;
        bus_dout_s = cpu_dout;
      end
    endcase
  end

  assign bus_we   = bus_we_s;
  assign bus_addr = bus_addr_s;
  assign bus_dout = bus_dout_s;
  assign cpu_rdy  = cpu_rdy_r;
  assign dma_busy = dma_busy_r;

endmodule
